// File: rtl/rv32i_fetch_controller.sv
// RV32I instruction-fetch sequencer: owns the PC, issues one imem request at a time,
// buffers responses (output register + 1-entry skid) and handles redirects.
// Optional misaligned-redirect trap enabled by defining RV32I_FETCH_MISALIGN_TRAP_EN.
module rv32i_fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        misaligned_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] issued_pc_q, issued_pc_d;
  logic        out_vld_q, out_vld_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        err_q, err_d;
  logic        fault_pend_q, fault_pend_d;

  logic        issue;
  logic        consume;
  logic        outstanding;
  logic        redir_mis;
  logic [31:0] redir_tgt;

  assign imem_req  = (state_q == S_REQ) && !skid_vld_q;
  assign issue     = imem_req && imem_gnt;
  assign consume   = out_vld_q && if_ready;
  assign redir_tgt = {redirect_pc[31:2], 2'b00};

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
  assign redir_mis = (redirect_pc[1:0] != 2'b00);
`else
  logic unused_redir_lsbs;
  assign unused_redir_lsbs = ^redirect_pc[1:0];
  assign redir_mis         = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    issued_pc_d  = issued_pc_q;
    out_vld_d    = out_vld_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    skid_vld_d   = skid_vld_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    fault_pend_d = fault_pend_q;
    outstanding  = 1'b0;

    if (consume) begin
      if (skid_vld_q) begin
        out_pc_d    = skid_pc_q;
        out_instr_d = skid_instr_q;
        skid_vld_d  = 1'b0;
      end else begin
        out_vld_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (issue) begin
          state_d     = S_WAIT;
          issued_pc_d = pc_q;
        end
      end
      S_WAIT: begin
        // Skid is always empty here: requests are only issued with the skid free.
        if (imem_rvalid) begin
          state_d = S_REQ;
          pc_d    = issued_pc_q + 32'd4;
          if (!out_vld_q || consume) begin
            out_vld_d   = 1'b1;
            out_pc_d    = issued_pc_q;
            out_instr_d = imem_rdata;
          end else begin
            skid_vld_d   = 1'b1;
            skid_pc_d    = issued_pc_q;
            skid_instr_d = imem_rdata;
          end
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          state_d      = fault_pend_q ? S_FAULT : S_REQ;
          fault_pend_d = 1'b0;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid && (state_q != S_IDLE)) begin
      pc_d         = redir_tgt;
      out_vld_d    = 1'b0;
      skid_vld_d   = 1'b0;
      fault_pend_d = 1'b0;
      outstanding  = ((state_q == S_WAIT) && !imem_rvalid) ||
                     ((state_q == S_DROP) && !imem_rvalid) ||
                     ((state_q == S_REQ) && issue);
      if (outstanding) begin
        state_d      = S_DROP;
        fault_pend_d = redir_mis;
      end else begin
        state_d = redir_mis ? S_FAULT : S_REQ;
      end
    end

    err_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      out_vld_q    <= 1'b0;
      out_pc_q     <= 32'd0;
      out_instr_q  <= 32'd0;
      skid_vld_q   <= 1'b0;
      err_q        <= 1'b0;
      fault_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      out_vld_q    <= out_vld_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
      skid_vld_q   <= skid_vld_d;
      err_q        <= err_d;
      fault_pend_q <= fault_pend_d;
    end
  end

  // Payload-only registers; their validity is tracked by the reset control flops.
  always_ff @(posedge clk) begin
    issued_pc_q  <= issued_pc_d;
    skid_pc_q    <= skid_pc_d;
    skid_instr_q <= skid_instr_d;
  end

  assign imem_addr      = pc_q;
  assign if_valid       = out_vld_q;
  assign if_pc          = out_pc_q;
  assign if_instr       = out_instr_q;
  assign misaligned_err = err_q;

endmodule

// File: tb/tb_rv32i_fetch_controller.sv
// Bench for rv32i_fetch_controller: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model of the fetch stage.
module tb_rv32i_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        misaligned_err;

  always #5 clk = ~clk;

  rv32i_fetch_controller #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .misaligned_err(misaligned_err)
  );

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  // Behavioural model: delivered-word queue, pending-request bookkeeping, fault flags.
  bit          m_started;
  logic [31:0] m_pc;
  bit          m_pend, m_stale;
  logic [31:0] m_pend_pc;
  bit          m_fault, m_fault_pend;
  logic [63:0] m_q[$];

  // Memory environment.
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          mem_delay;

  logic [31:0] issued[$];
  logic [31:0] delivered[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F17;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit exp_req();
    return m_started && !m_pend && !m_fault && (m_q.size() < 2);
  endfunction

  task automatic compare_outputs();
    logic [63:0] head;
    check("imem_req", imem_req, exp_req());
    check("imem_addr", imem_addr, m_pc);
    check("if_valid", if_valid, m_q.size() > 0);
    check("misaligned_err", misaligned_err, m_fault);
    if (m_q.size() > 0) begin
      head = m_q[0];
      check("if_pc", if_pc, head[63:32]);
      check("if_instr", if_instr, head[31:0]);
    end
  endtask

  task automatic model_update();
    bit req, consume, issue, resp, mis;
    if (!rst_n) begin
      m_started = 0; m_pc = 32'h0; m_pend = 0; m_stale = 0;
      m_fault = 0; m_fault_pend = 0; m_q.delete();
    end else if (!m_started) begin
      m_started = 1;
    end else begin
      req     = exp_req();
      consume = (m_q.size() > 0) && if_ready;
      issue   = req && imem_gnt;
      resp    = m_pend && imem_rvalid;
      if (redirect_valid) begin
        mis  = TRAP && (redirect_pc[1:0] != 2'b00);
        m_pc = {redirect_pc[31:2], 2'b00};
        m_q.delete();
        if (resp) m_pend = 0;
        if (issue) m_pend = 1;
        if (m_pend) m_stale = 1;
        if (mis) begin
          m_fault_pend = m_pend;
          m_fault      = !m_pend;
        end else begin
          m_fault      = 0;
          m_fault_pend = 0;
        end
      end else begin
        if (consume) void'(m_q.pop_front());
        if (resp) begin
          m_pend = 0;
          if (!m_stale) begin
            m_q.push_back({m_pend_pc, imem_rdata});
            m_pc = m_pend_pc + 32'd4;
          end else if (m_fault_pend) begin
            m_fault      = 1;
            m_fault_pend = 0;
          end
          m_stale = 0;
        end
        if (issue) begin
          m_pend    = 1;
          m_stale   = 0;
          m_pend_pc = m_pc;
        end
      end
    end
  endtask

  // One cycle: compare at the negedge, drive inputs, advance model and memory, wait.
  task automatic step(input bit rstn, input bit rv, input logic [31:0] rp,
                      input bit gnt, input bit rdy);
    compare_outputs();
    rst_n          = rstn;
    redirect_valid = rv;
    redirect_pc    = rp;
    imem_gnt       = gnt;
    if_ready       = rdy;
    imem_rvalid    = mem_busy && (mem_cnt == 0);
    imem_rdata     = imem_rvalid ? word_of(mem_addr) : $urandom;
    if (rstn && imem_req && gnt) issued.push_back(imem_addr);
    if (rstn && if_valid && rdy) delivered.push_back(if_pc);
    model_update();
    if (!rstn) begin
      mem_busy = 0;
    end else begin
      if (imem_rvalid) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (imem_req && gnt) begin
        check("single_outstanding", {31'd0, mem_busy}, 32'd0);
        mem_busy = 1;
        mem_cnt  = (mem_delay < 0) ? int'($urandom_range(0, 2)) : mem_delay;
        mem_addr = imem_addr;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(0, 0, 32'h0, 0, 0);
    step(0, 0, 32'h0, 0, 0);
  endtask

  task automatic wait_req(input bit gnt, input int max);
    int n = 0;
    while (!imem_req && n < max) begin
      step(1, 0, 32'h0, gnt, 1);
      n++;
    end
    check("wait_req", {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    bit found;
    bit saw8;
    logic [31:0] tgt;
    rst_n = 0; redirect_valid = 0; redirect_pc = 0; imem_gnt = 0;
    imem_rvalid = 0; imem_rdata = 0; if_ready = 0;
    mem_busy = 0; mem_cnt = 0; mem_addr = 0; mem_delay = 0;
    m_started = 0; m_pc = 0; m_pend = 0; m_stale = 0; m_pend_pc = 0;
    m_fault = 0; m_fault_pend = 0;
    @(negedge clk);

    // Reset values
    do_reset();
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_err", {31'd0, misaligned_err}, 32'd0);

    // Best-case streaming
    issued.delete(); delivered.delete();
    for (int i = 0; i < 10; i++) step(1, 0, 32'h0, 1, 1);
    check("stream_issue_cnt", issued.size(), 5);
    check("stream_addr0", issued[0], 32'h0);
    check("stream_addr1", issued[1], 32'h4);
    check("stream_addr2", issued[2], 32'h8);
    check("stream_deliv_cnt", delivered.size(), 4);
    check("stream_pc0", delivered[0], 32'h0);
    check("stream_pc1", delivered[1], 32'h4);
    check("stream_pc2", delivered[2], 32'h8);

    // Back-pressure: output + skid fill, requests stop
    issued.delete(); delivered.delete();
    for (int i = 0; i < 6; i++) step(1, 0, 32'h0, 1, 0);
    check("bp_issue_cnt", issued.size(), 1);
    check("bp_req_held", {31'd0, imem_req}, 32'd0);
    check("bp_if_valid", {31'd0, if_valid}, 32'd1);
    check("bp_if_pc", if_pc, 32'h10);
    for (int i = 0; i < 4; i++) step(1, 0, 32'h0, 1, 1);
    check("bp_deliv_cnt", delivered.size() >= 2, 1);
    check("bp_deliv0", delivered[0], 32'h10);
    check("bp_deliv1", delivered[1], 32'h14);

    // Redirect while a response is still in flight
    do_reset();
    mem_delay = 1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem_req && imem_addr == 32'h8) found = 1;
      else step(1, 0, 32'h0, 1, 1);
    end
    check("r1_reach_8", {31'd0, found}, 32'd1);
    step(1, 0, 32'h0, 1, 1);
    step(1, 1, 32'h100, 1, 1);
    check("r1_drop_req", {31'd0, imem_req}, 32'd0);
    delivered.delete();
    step(1, 0, 32'h0, 1, 1);
    check("r1_req", {31'd0, imem_req}, 32'd1);
    check("r1_addr", imem_addr, 32'h100);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (if_valid && if_pc == 32'h100) found = 1;
      else step(1, 0, 32'h0, 1, 1);
    end
    check("r1_if_pc_100", {31'd0, found}, 32'd1);
    check("r1_if_instr", if_instr, word_of(32'h100));
    saw8 = 0;
    foreach (delivered[i]) if (delivered[i] == 32'h8) saw8 = 1;
    check("r1_stale_dropped", {31'd0, saw8}, 32'd0);

    // Redirect coinciding with rvalid
    mem_delay = 0;
    wait_req(1, 10);
    step(1, 0, 32'h0, 1, 1);
    step(1, 1, 32'h200, 1, 1);
    check("r2_req", {31'd0, imem_req}, 32'd1);
    check("r2_addr", imem_addr, 32'h200);
    check("r2_if_valid", {31'd0, if_valid}, 32'd0);

    // PC wrap
    wait_req(0, 10);
    step(1, 1, 32'hFFFF_FFFC, 0, 1);
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    step(1, 0, 32'h0, 1, 1);
    step(1, 0, 32'h0, 0, 1);
    check("wrap_req", {31'd0, imem_req}, 32'd1);
    check("wrap_addr_zero", imem_addr, 32'h0);
    check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);

    // Misaligned redirect
    wait_req(0, 10);
    step(1, 1, 32'h102, 0, 1);
    if (TRAP) begin
      check("mis_err", {31'd0, misaligned_err}, 32'd1);
      check("mis_no_req", {31'd0, imem_req}, 32'd0);
      for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 1, 1);
      check("mis_still_no_req", {31'd0, imem_req}, 32'd0);
      check("mis_if_valid", {31'd0, if_valid}, 32'd0);
    end else begin
      check("mis_err_off", {31'd0, misaligned_err}, 32'd0);
      check("mis_addr_forced", imem_addr, 32'h100);
      check("mis_req_off", {31'd0, imem_req}, 32'd1);
    end
    step(1, 1, 32'h104, 0, 1);
    check("mis_clear_err", {31'd0, misaligned_err}, 32'd0);
    check("mis_resume_req", {31'd0, imem_req}, 32'd1);
    check("mis_resume_addr", imem_addr, 32'h104);

    // Randomized traffic with occasional resets
    mem_delay = -1;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        step(0, 0, 32'h0, 0, 0);
      end else begin
        tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                          : {20'h0, 12'($urandom)};
        step(1, $urandom_range(0, 99) < 6, tgt,
             $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
      end
    end
    compare_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
